// File: rtl/tube_pkg.sv
// Shared types and constants for the drift-tube readout sequencer.
package tube_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam logic [7:0]  TUBE_SAT  = 8'd255;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StCapture,
        StRead,
        StHold
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16
    import tube_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= sat_inc16(cnt_q);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tube_readout_ctrl.sv
// Trigger-driven sequencer: clears the tube bank, gates it, snapshots the counts
// and streams them one tube per word over valid/ready.
module tube_readout_ctrl
    import tube_pkg::*;
#(
    parameter int unsigned NUM_TUBES      = 8,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned GATE_CYCLES    = 200,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned IDX_W          = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       trig,
    input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
    output logic                       tube_clr,
    output logic                       gate_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic [15:0]                evt_cnt,
    output logic [15:0]                drop_cnt
);

    localparam logic [15:0]      GATE_LOAD = 16'(GATE_CYCLES - 1);
    localparam logic [15:0]      HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? 16'd0
                                                                   : 16'(HOLDOFF_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TUBES - 1);

    state_e                     state_q, state_d;
    logic                       trig_q;
    logic [15:0]                timer_q, timer_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_TUBES*CNT_W-1:0] snap_q;

    logic trig_edge;
    logic in_read;
    logic xfer;
    logic evt_inc;
    logic drop_inc;

    assign trig_edge = trig & ~trig_q;
    assign in_read   = (state_q == StRead);
    assign xfer      = in_read & out_ready;
    // A trigger is only accepted in IDLE; everything else, including the
    // cycle that returns to IDLE, is counted as dropped.
    assign evt_inc   = trig_edge & (state_q == StIdle);
    assign drop_inc  = trig_edge & (state_q != StIdle);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            timer_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            if (state_q == StCapture) begin
                snap_q <= tube_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (trig_edge) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                timer_d = GATE_LOAD;
                state_d = StGate;
            end
            StGate: begin
                if (timer_q == 16'd0) begin
                    state_d = StCapture;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            StCapture: begin
                idx_d   = '0;
                state_d = StRead;
            end
            StRead: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        if (HOLDOFF_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            timer_d = HOLD_LOAD;
                            state_d = StHold;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (timer_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs; readout fields are forced to zero outside READ.
    always_comb begin
        tube_clr  = clr | (state_q == StClear);
        gate_en   = (state_q == StGate);
        busy      = (state_q != StIdle);
        out_valid = in_read;
        out_idx   = '0;
        out_data  = '0;
        out_last  = 1'b0;
        if (in_read) begin
            out_idx  = idx_q;
            out_data = snap_q[idx_q*CNT_W +: CNT_W];
            out_last = (idx_q == LAST_IDX);
        end
    end

    sat_counter16 u_evt_cnt (
        .clk (clk),
        .clr (clr),
        .inc (evt_inc),
        .cnt (evt_cnt)
    );

    sat_counter16 u_drop_cnt (
        .clk (clk),
        .clr (clr),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

endmodule

// File: doc/tube_readout_ctrl.md
Name: tube_readout_ctrl

Overview:
- Event sequencer for a bank of NUM_TUBES drift-tube timing counters. Each tube counter counts clk cycles while its tube latch is open and saturates at 255.
- On a scintillator trigger the block clears the bank, opens the gate window, and snapshots all counters when the window closes.
- It then streams the snapshot one tube per word over a valid/ready interface to the readout/FIFO logic.
- It sits between the trigger input and the tube bank, and owns the bank's clear and gate-enable lines.

Parameters:
- NUM_TUBES, 8: number of tube counters in the bank.
- CNT_W, 8: width of each tube count.
- GATE_CYCLES, 200: gate window length in clk cycles (1..65535).
- HOLDOFF_CYCLES, 4: dead time after readout before re-arming (0 allowed).
- IDX_W, $clog2(NUM_TUBES) (minimum 1): tube index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-high reset.
- trig  in  1  scintillator trigger, synchronous to clk, level; a rising edge starts an event.
- tube_data  in  NUM_TUBES*CNT_W  flattened tube counts; tube i occupies bits [i*CNT_W +: CNT_W].
- tube_clr  out  1  clear to the tube bank (latches and counters).
- gate_en  out  1  gate enable to the tube bank.
- out_valid  out  1  a readout word is presented.
- out_ready  in  1  consumer accepts the word.
- out_data  out  CNT_W  captured count for tube out_idx.
- out_idx  out  IDX_W  tube index of the current word.
- out_last  out  1  high with the word for tube NUM_TUBES-1.
- busy  out  1  high whenever state != IDLE.
- evt_cnt  out  16  accepted events; saturating.
- drop_cnt  out  16  triggers ignored because busy; saturating.

Behaviour:
- Reset (clr high, async): state=IDLE; gate_en=0, out_valid=0, out_idx=0, out_last=0, busy=0, evt_cnt=0, drop_cnt=0, snapshot=0, trig edge register=0.
  - tube_clr = clr OR (state==CLEAR); the bank is held cleared during reset.
  - Reset mid-event aborts immediately. No partial word is emitted after clr deasserts.
- Trigger edge: trig_q registered; edge = trig & ~trig_q.
  - Edge in IDLE: start event, evt_cnt+1.
  - Edge in any other state: drop_cnt+1, no other effect.
  - An edge in the same cycle the FSM returns to IDLE counts as dropped.
- States (Moore outputs):
  - IDLE -> CLEAR on edge.
  - CLEAR (1 cycle): tube_clr=1, gate_en=0 -> GATE.
  - GATE: gate_en=1 for exactly GATE_CYCLES cycles, counted by a 16-bit down-counter loaded in CLEAR. Next cycle -> CAPTURE.
  - CAPTURE (1 cycle): gate_en=0. Register all of tube_data into the snapshot; index=0 -> READ.
  - READ: out_valid=1, out_data=snapshot[index], out_idx=index, out_last=(index==NUM_TUBES-1).
    - Transfer occurs when out_valid & out_ready.
    - On a transfer with index<NUM_TUBES-1: index+1.
    - On a transfer with out_last: -> HOLD.
    - While out_ready=0 all out_* are held stable.
  - HOLD: wait HOLDOFF_CYCLES cycles (0 means straight through) -> IDLE.
- Latency:
  - Trigger edge to gate_en rise: 2 cycles (CLEAR, then GATE).
  - gate_en fall to first out_valid: 1 cycle (CAPTURE).
- Snapshot content: counts are frozen at CAPTURE. Tube counters keep running afterwards, but later changes never appear in the output.
- The block does not interpret counts; 255 means no hit or saturated.
- Counters: evt_cnt and drop_cnt stick at 16'hFFFF.

Decomposition:
- Shared package tube_pkg:
  - state enum (IDLE, CLEAR, GATE, CAPTURE, READ, HOLD)
  - CNT_W default and the TUBE_SAT=255 constant
- Natural sub-module: sat_counter16 (increment-enable, saturating at 16'hFFFF, async clear), instantiated twice for evt_cnt and drop_cnt.

Test Plan:
All cases use NUM_TUBES=4, GATE_CYCLES=20, HOLDOFF_CYCLES=4.
- Basic event: pulse trig with out_ready=1 and tube_data={8'd40,8'd255,8'd7,8'd13} held from CAPTURE on.
  - tube_clr for 1 cycle, then gate_en high for exactly 20 cycles.
  - Words, idx 0..3: 13, 7, 255, 40; out_last only on idx 3; evt_cnt=1.
- Backpressure: out_ready low for 5 cycles at idx 1, toggle it thereafter.
  - out_data, out_idx and out_valid stay stable while stalled.
  - No word is skipped or duplicated; exactly 4 transfers.
- Snapshot freeze: change tube_data every cycle after CAPTURE.
  - The emitted words equal the values present in the CAPTURE cycle.
- Trigger while busy: 3 trig edges during GATE/READ plus 1 edge coinciding with the HOLD->IDLE transition.
  - drop_cnt=4, evt_cnt=1, and no restart.
  - A subsequent edge in IDLE starts event 2.
- Async reset mid-READ: assert clr at idx 2.
  - All outputs go to 0 within the same cycle; tube_clr=1 while clr is high.
  - After release: IDLE, busy=0, no out_valid until a new trigger.
- Saturation: preload via 65537 dropped triggers, or force drop_cnt=16'hFFFE.
  - drop_cnt sticks at 16'hFFFF and does not wrap.
